// File: rtl/hub75_receiver.sv
// HUB75 bus receiver: synchronises the panel bus, then reports pixels, latched lines
// with bit-plane tracking, and the width of each output-enable pulse.
module hub75_receiver #(
  parameter int COLUMNS     = 64,
  parameter int PLANES      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        hub_clk_pixel,
  input  logic        hub_row_latch,
  input  logic        hub_output_enable_n,
  input  logic [3:0]  hub_row_address,
  input  logic [2:0]  hub_rgb1,
  input  logic [2:0]  hub_rgb2,
  output logic        pixel_valid,
  output logic [7:0]  pixel_column,
  output logic [2:0]  pixel_rgb1,
  output logic [2:0]  pixel_rgb2,
  output logic        line_valid,
  output logic [3:0]  line_row,
  output logic [2:0]  line_plane,
  output logic [8:0]  line_length,
  output logic        line_error,
  output logic [15:0] oe_cycles,
  output logic        oe_valid
);

  // Bus word layout: {pixel clk, latch, #OE, row[3:0], rgb1[2:0], rgb2[2:0]}
  localparam int              BW           = 13;
  localparam logic [BW-1:0]   BUS_IDLE     = 13'b0_0_1_0000_000_000;
  localparam logic [8:0]      LINE_COLUMNS = 9'(COLUMNS);
  localparam logic [3:0]      PLANE_LAST   = 4'(PLANES - 1);

  logic [BW-1:0] bus_sync [SYNC_STAGES];
  logic [BW-1:0] bus_now;
  logic          prev_clk, prev_latch, prev_oe_n;
  logic          pixel_edge, latch_edge, oe_fall, oe_rise;
  logic [8:0]    count, count_inc, line_len_next;
  logic [3:0]    last_row;
  logic [2:0]    last_plane;
  logic          first_done;
  logic [3:0]    plane_cand;
  logic [2:0]    plane_next;
  logic          plane_over;
  logic [15:0]   oe_count;

  assign bus_now = bus_sync[SYNC_STAGES-1];

  // Data travels through the same chain as the strobes so both stay aligned.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) bus_sync[i] <= BUS_IDLE;
      prev_clk   <= 1'b0;
      prev_latch <= 1'b0;
      prev_oe_n  <= 1'b1;
    end else begin
      bus_sync[0] <= {hub_clk_pixel, hub_row_latch, hub_output_enable_n,
                      hub_row_address, hub_rgb1, hub_rgb2};
      for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
      prev_clk   <= bus_now[12];
      prev_latch <= bus_now[11];
      prev_oe_n  <= bus_now[10];
    end
  end

  always_comb begin
    pixel_edge    = bus_now[12] & ~prev_clk;
    latch_edge    = bus_now[11] & ~prev_latch;
    oe_fall       = ~bus_now[10] & prev_oe_n;
    oe_rise       = bus_now[10] & ~prev_oe_n;
    count_inc     = (count == 9'd511) ? count : count + 9'd1;
    // A pixel arriving with the latch belongs to the line being committed.
    line_len_next = pixel_edge ? count_inc : count;
    if (first_done && (bus_now[9:6] == last_row)) begin
      plane_cand = {1'b0, last_plane} + 4'd1;
    end else begin
      plane_cand = 4'd0;
    end
    plane_over = (plane_cand > PLANE_LAST);
    plane_next = plane_over ? PLANE_LAST[2:0] : plane_cand[2:0];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pixel_valid  <= 1'b0;
      pixel_column <= 8'd0;
      pixel_rgb1   <= 3'd0;
      pixel_rgb2   <= 3'd0;
      line_valid   <= 1'b0;
      line_row     <= 4'd0;
      line_plane   <= 3'd0;
      line_length  <= 9'd0;
      line_error   <= 1'b0;
      oe_cycles    <= 16'd0;
      oe_valid     <= 1'b0;
      count        <= 9'd0;
      last_row     <= 4'd0;
      last_plane   <= 3'd0;
      first_done   <= 1'b0;
      oe_count     <= 16'd0;
    end else begin
      pixel_valid <= pixel_edge;
      line_valid  <= latch_edge;
      oe_valid    <= oe_rise;
      if (pixel_edge) begin
        pixel_column <= count[7:0];
        pixel_rgb1   <= bus_now[5:3];
        pixel_rgb2   <= bus_now[2:0];
      end
      if (latch_edge) begin
        line_row    <= bus_now[9:6];
        line_plane  <= plane_next;
        line_length <= line_len_next;
        line_error  <= plane_over | (line_len_next != LINE_COLUMNS);
        last_row    <= bus_now[9:6];
        last_plane  <= plane_next;
        first_done  <= 1'b1;
        count       <= 9'd0;
      end else if (pixel_edge) begin
        count <= count_inc;
      end
      // The falling-edge cycle is already a low cycle, so the count starts at 1.
      if (oe_fall) begin
        oe_count <= 16'd1;
      end else if (!bus_now[10] && (oe_count != 16'hFFFF)) begin
        oe_count <= oe_count + 16'd1;
      end
      if (oe_rise) begin
        oe_cycles <= oe_count;
      end
    end
  end

endmodule

// File: tb/tb_hub75_receiver.sv
// Self-checking bench for hub75_receiver: drives the bus slowly and compares every
// strobe against a transaction-level model of pixels, lines and enable pulses.
module tb_hub75_receiver;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        hub_clk_pixel, hub_row_latch, hub_output_enable_n;
  logic [3:0]  hub_row_address;
  logic [2:0]  hub_rgb1, hub_rgb2;
  logic        pixel_valid, line_valid, line_error, oe_valid;
  logic [7:0]  pixel_column;
  logic [2:0]  pixel_rgb1, pixel_rgb2, line_plane;
  logic [3:0]  line_row;
  logic [8:0]  line_length;
  logic [15:0] oe_cycles;

  hub75_receiver dut (
    .clk_in(clk_in), .reset(reset),
    .hub_clk_pixel(hub_clk_pixel), .hub_row_latch(hub_row_latch),
    .hub_output_enable_n(hub_output_enable_n), .hub_row_address(hub_row_address),
    .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
    .pixel_valid(pixel_valid), .pixel_column(pixel_column),
    .pixel_rgb1(pixel_rgb1), .pixel_rgb2(pixel_rgb2),
    .line_valid(line_valid), .line_row(line_row), .line_plane(line_plane),
    .line_length(line_length), .line_error(line_error),
    .oe_cycles(oe_cycles), .oe_valid(oe_valid)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] column;
    logic [2:0] rgb1;
    logic [2:0] rgb2;
  } pix_t;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] plane;
    logic [8:0] length;
    logic       error;
  } line_t;

  pix_t        exp_pix[$], obs_pix[$];
  line_t       exp_line[$], obs_line[$];
  logic [15:0] exp_oe[$], obs_oe[$];

  int n_asserts = 0;
  int n_fails   = 0;

  // Model state: pixels since last commit, and the last committed row/plane.
  int m_count;
  bit m_seen;
  int m_last_row, m_last_plane;

  always @(negedge clk_in) begin
    if (pixel_valid) obs_pix.push_back('{pixel_column, pixel_rgb1, pixel_rgb2});
    if (line_valid)  obs_line.push_back('{line_row, line_plane, line_length, line_error});
    if (oe_valid)    obs_oe.push_back(oe_cycles);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_seen  = 1'b0;
    m_last_row = 0;
    m_last_plane = 0;
  endtask

  task automatic model_pixel(input logic [2:0] r1, input logic [2:0] r2);
    exp_pix.push_back('{8'(m_count % 256), r1, r2});
    if (m_count < 511) m_count++;
  endtask

  task automatic model_latch(input int row);
    int p;
    bit err;
    p = (m_seen && row == m_last_row) ? m_last_plane + 1 : 0;
    err = (m_count != 64);
    if (p > 5) begin
      p = 5;
      err = 1'b1;
    end
    exp_line.push_back('{4'(row), 3'(p), 9'(m_count), err});
    m_last_row = row;
    m_last_plane = p;
    m_seen = 1'b1;
    m_count = 0;
  endtask

  task automatic send_pixel(input logic [2:0] r1, input logic [2:0] r2);
    hub_rgb1 = r1;
    hub_rgb2 = r2;
    cyc(3);
    hub_clk_pixel = 1'b1;
    model_pixel(r1, r2);
    cyc(3);
    hub_clk_pixel = 1'b0;
  endtask

  task automatic send_random_pixels(input int n);
    for (int i = 0; i < n; i++) send_pixel(3'($urandom), 3'($urandom));
  endtask

  task automatic send_latch(input int row);
    hub_row_address = 4'(row);
    cyc(3);
    hub_row_latch = 1'b1;
    model_latch(row);
    cyc(3);
    hub_row_latch = 1'b0;
    cyc(3);
  endtask

  task automatic send_oe(input int width);
    hub_output_enable_n = 1'b0;
    cyc(width);
    hub_output_enable_n = 1'b1;
    exp_oe.push_back((width > 65535) ? 16'hFFFF : 16'(width));
    cyc(3);
  endtask

  // Drain the pipeline, then pair every expected transaction with an observed one.
  task automatic check_all();
    pix_t  ep, op;
    line_t el, ol;
    logic [15:0] eo, oo;
    cyc(8);
    while (exp_pix.size() > 0) begin
      ep = exp_pix.pop_front();
      if (obs_pix.size() == 0) chk("pixel_missing", 0, 1);
      else begin
        op = obs_pix.pop_front();
        chk("pixel_column", op.column, ep.column);
        chk("pixel_rgb1", op.rgb1, ep.rgb1);
        chk("pixel_rgb2", op.rgb2, ep.rgb2);
      end
    end
    chk("pixel_extra", obs_pix.size(), 0);
    obs_pix.delete();
    while (exp_line.size() > 0) begin
      el = exp_line.pop_front();
      if (obs_line.size() == 0) chk("line_missing", 0, 1);
      else begin
        ol = obs_line.pop_front();
        chk("line_row", ol.row, el.row);
        chk("line_plane", ol.plane, el.plane);
        chk("line_length", ol.length, el.length);
        chk("line_error", ol.error, el.error);
      end
    end
    chk("line_extra", obs_line.size(), 0);
    obs_line.delete();
    while (exp_oe.size() > 0) begin
      eo = exp_oe.pop_front();
      if (obs_oe.size() == 0) chk("oe_missing", 0, 1);
      else begin
        oo = obs_oe.pop_front();
        chk("oe_cycles", oo, eo);
      end
    end
    chk("oe_extra", obs_oe.size(), 0);
    obs_oe.delete();
  endtask

  initial begin
    reset = 1'b1;
    hub_clk_pixel = 1'b0;
    hub_row_latch = 1'b0;
    hub_output_enable_n = 1'b1;
    hub_row_address = 4'd0;
    hub_rgb1 = 3'd0;
    hub_rgb2 = 3'd0;
    model_reset();
    cyc(5);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_column", pixel_column, 0);
    chk("rst_pixel_rgb", {pixel_rgb1, pixel_rgb2}, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_fields", {line_row, line_plane, line_length, line_error}, 0);
    chk("rst_oe", {oe_valid, oe_cycles}, 0);
    reset = 1'b0;
    check_all();

    // Full line with fixed colours on row 5.
    for (int i = 0; i < 64; i++) send_pixel(3'b101, 3'b010);
    send_latch(5);
    check_all();

    // Repeat row 5 until the plane index overflows, then change row.
    for (int k = 0; k < 6; k++) begin
      send_random_pixels(64);
      send_latch(5);
      check_all();
    end
    send_random_pixels(64);
    send_latch(6);
    check_all();

    // Short line, then an overlong line whose column wraps past 255.
    send_random_pixels(63);
    send_latch(6);
    send_random_pixels(300);
    send_latch(9);
    check_all();

    // A random-length line on a random row.
    send_random_pixels(int'($urandom_range(1, 80)));
    send_latch(int'($urandom_range(0, 15)));
    check_all();

    // Pixel and latch rising edges arrive in the same cycle.
    send_random_pixels(63);
    hub_rgb1 = 3'b011;
    hub_rgb2 = 3'b110;
    hub_row_address = 4'd2;
    cyc(3);
    hub_clk_pixel = 1'b1;
    hub_row_latch = 1'b1;
    model_pixel(3'b011, 3'b110);
    model_latch(2);
    cyc(3);
    hub_clk_pixel = 1'b0;
    hub_row_latch = 1'b0;
    send_pixel(3'b111, 3'b001);
    check_all();

    // Reset in mid-line drops the partial count and the plane history.
    send_random_pixels(29);
    check_all();
    reset = 1'b1;
    cyc(4);
    reset = 1'b0;
    model_reset();
    check_all();
    send_random_pixels(64);
    send_latch(2);
    check_all();

    // Output-enable pulse width, exact and saturated.
    send_oe(40);
    check_all();
    send_oe(70000);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
